// File: rtl/frame_sequencer.sv
// Frame sequencer: streams an IMG_WIDTH x IMG_HEIGHT frame from memory into the pipeline, then waits for its results.
// Compile option FRAME_SEQ_HBLANK_EN inserts HBLANK idle cycles after every row except the last.
module frame_sequencer #(
  parameter int IMG_WIDTH     = 512,
  parameter int IMG_HEIGHT    = 512,
  parameter int EXPECTED_OUT  = 262144,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int HBLANK        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  output logic [17:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic [7:0]  pixel_out,
  output logic        pixel_out_valid,
  input  logic        result_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout,
  output logic [8:0]  row,
  output logic [8:0]  col
);
  localparam int RW = $clog2(EXPECTED_OUT + 1);
  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, STREAM, BLANK, DRAIN, DONE} state_t;

  state_t        state;
  logic [RW-1:0] res_cnt;
  logic [DW-1:0] quiet_cnt;
`ifdef FRAME_SEQ_HBLANK_EN
  logic [15:0]   blank_cnt;
`endif

  logic last_col, last_row, res_full, quiet_expired;

  assign last_col      = (col == 9'(IMG_WIDTH - 1));
  assign last_row      = (row == 9'(IMG_HEIGHT - 1));
  assign res_full      = (res_cnt == RW'(EXPECTED_OUT));
  assign quiet_expired = (quiet_cnt == DW'(DRAIN_TIMEOUT - 1));

  // NOTE: the read strobe is decoded from state and hold directly so that hold
  // suppresses the read in the very cycle it is raised.
  assign mem_rd_en = (state == STREAM) && !hold;
  assign pixel_out = pixel_out_valid ? mem_rd_data : 8'd0;

  // quiet_cnt holds cycles since the last result, so timeout lands DRAIN_TIMEOUT cycles after it.
  // NOTE: all state and registered outputs use non-blocking assignments in this one block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      mem_addr        <= '0;
      row             <= '0;
      col             <= '0;
      pixel_out_valid <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      timeout         <= 1'b0;
      res_cnt         <= '0;
      quiet_cnt       <= '0;
`ifdef FRAME_SEQ_HBLANK_EN
      blank_cnt       <= '0;
`endif
    end else begin
      pixel_out_valid <= mem_rd_en;
      frame_done      <= 1'b0;

      if (state != IDLE) begin
        if (result_valid) begin
          if (!res_full) res_cnt <= res_cnt + RW'(1);
          quiet_cnt <= DW'(1);
        end else if (!quiet_expired) begin
          quiet_cnt <= quiet_cnt + DW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            busy      <= 1'b1;
            timeout   <= 1'b0;
            mem_addr  <= '0;
            row       <= '0;
            col       <= '0;
            res_cnt   <= '0;
            quiet_cnt <= '0;
          end
        end

        STREAM: begin
          if (!hold) begin
            mem_addr <= mem_addr + 18'd1;
            if (!last_col) begin
              col <= col + 9'd1;
            end else begin
              col <= '0;
              if (last_row) begin
                state <= DRAIN;
              end else begin
                row <= row + 9'd1;
`ifdef FRAME_SEQ_HBLANK_EN
                if (HBLANK > 0) begin
                  state     <= BLANK;
                  blank_cnt <= '0;
                end
`endif
              end
            end
          end
        end

        BLANK: begin
`ifdef FRAME_SEQ_HBLANK_EN
          if (blank_cnt == 16'(HBLANK - 1)) state <= STREAM;
          else                              blank_cnt <= blank_cnt + 16'd1;
`else
          state <= STREAM;
`endif
        end

        DRAIN: begin
          if (res_full) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else if (!result_valid && quiet_expired) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 512, pixels per row.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 512, rows per frame.
REQ-003 The block SHALL have parameter EXPECTED_OUT, default 262144, result beats that end a frame.
REQ-004 The block SHALL have parameter DRAIN_TIMEOUT, default 4096, idle drain cycles before abort.
REQ-005 The block SHALL have parameter HBLANK, default 4, gap cycles inserted after each row (used only with the Configuration macro).
REQ-006 The block SHALL use one clock and an asynchronous active-high reset: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-007 The block SHALL have the ports: start  in  1  frame start request (level, sampled in IDLE); hold  in  1  suspends new reads.
REQ-008 The block SHALL have the ports: mem_addr  out  18  frame memory read address; mem_rd_en  out  1  read strobe; mem_rd_data  in  8  read data, valid one cycle after mem_rd_en.
REQ-009 The block SHALL have the ports: pixel_out  out  8  pixel to pipeline (pixel_loader pixel_in); pixel_out_valid  out  1  pixel strobe.
REQ-010 The block SHALL have the ports: result_valid  in  1  pipeline result strobe (gradient_out_valid); busy  out  1  frame in progress; frame_done  out  1  one-cycle completion pulse; timeout  out  1  sticky abort flag; row  out  9  and col  out  9  position of the current read.

Function
REQ-011 The block SHALL implement states IDLE, STREAM, BLANK, DRAIN, DONE.
REQ-012 IDLE SHALL go to STREAM when start=1; this clears timeout, row, col, the address counter and the result counter.
REQ-013 In STREAM with hold=0, the block SHALL assert mem_rd_en with mem_addr=row*IMG_WIDTH+col, then advance col, wrapping to 0 and incrementing row at IMG_WIDTH-1.
REQ-014 In STREAM with hold=1, mem_rd_en SHALL be 0 and the address, row and col SHALL not change.
REQ-015 pixel_out_valid SHALL be mem_rd_en delayed by one cycle (registered), and pixel_out SHALL equal mem_rd_data in that cycle; a read issued before hold rises still produces its beat.
REQ-016 After the read of the last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1), the block SHALL go to DRAIN.
REQ-017 In every state except IDLE, each result_valid=1 SHALL increment the result counter, which saturates at EXPECTED_OUT.
REQ-018 In DRAIN, when the result counter reaches EXPECTED_OUT the block SHALL go to DONE; if a result arrives in the same cycle as the last read, it SHALL count, and DONE SHALL follow DRAIN by one cycle.
REQ-019 In DRAIN, a cycle counter SHALL clear on every result_valid; reaching DRAIN_TIMEOUT SHALL set timeout and return to IDLE without a frame_done pulse.
REQ-020 DONE SHALL last one cycle and assert frame_done=1 in that cycle, then go to IDLE.
REQ-021 busy SHALL be 1 in STREAM, BLANK, DRAIN and DONE.
REQ-022 start SHALL be ignored outside IDLE; start held high SHALL begin the next frame on the first cycle after DONE returns to IDLE.

Reset
REQ-023 When rst=1, at any time including mid-frame, the block SHALL force IDLE and zero mem_addr, mem_rd_en, pixel_out, pixel_out_valid, busy, frame_done, timeout, row, col and all counters.
REQ-024 Leaving reset SHALL not start a frame unless start=1 is sampled in IDLE.

Configuration
REQ-025 The macro FRAME_SEQ_HBLANK_EN SHALL be the only compile option.
REQ-026 With FRAME_SEQ_HBLANK_EN defined, after each row's last read (except the final row), the block SHALL enter BLANK for HBLANK cycles with mem_rd_en=0, then return to STREAM; hold does not extend BLANK.
REQ-027 Without FRAME_SEQ_HBLANK_EN, BLANK SHALL be unreachable and rows SHALL stream back-to-back.

Verification
REQ-028 W=4, H=3, EXPECTED_OUT=12, mem[i]=i, start pulse, result_valid echoing pixel_out_valid -> 12 consecutive beats 0..11, frame_done once, at the 2nd cycle after the last beat.
REQ-029 Same setup, hold=1 for 3 cycles after the 5th read -> exactly one in-flight beat (value 4), then no beats for 3 cycles, then 5..11 with no loss or duplication.
REQ-030 EXPECTED_OUT=12, only 10 results returned, DRAIN_TIMEOUT=8 -> timeout=1 eight cycles after the last result, no frame_done, busy=0, then start clears timeout.
REQ-031 rst=1 asserted at the 6th read -> all outputs 0 immediately; the next start restarts at mem_addr=0.
REQ-032 With FRAME_SEQ_HBLANK_EN and HBLANK=2 -> exactly 2 idle cycles after beats 3 and 7, none after beat 11, frame total of 12 beats.
REQ-033 start held high for two frames -> second frame starts the cycle after frame_done's IDLE cycle, and result counter restarts from 0.
